// File: rtl/vga_line_scanout_if.sv
// VRAM line-fetch port between the scan-out engine (master) and the VRAM
// arbiter (slave); vram_turn tells the text writers when the port is theirs.
interface vga_line_scanout_if #(
    parameter int LINE_W = 640
);
    logic              vram_rd;
    logic [8:0]        vram_addr;
    logic [LINE_W-1:0] vram_line;
    logic              vram_valid;
    logic              vram_turn;

    modport master (
        output vram_rd,
        output vram_addr,
        output vram_turn,
        input  vram_line,
        input  vram_valid
    );

    modport slave (
        input  vram_rd,
        input  vram_addr,
        input  vram_turn,
        output vram_line,
        output vram_valid
    );
endinterface

// File: rtl/vga_line_scanout.sv
// Monochrome VGA scan-out: fetches the next display line from VRAM during
// horizontal blanking into a double buffer and shifts it out with sync.
module vga_line_scanout #(
    parameter int         CLK_DIV   = 4,
    parameter int         H_VISIBLE = 640,
    parameter int         H_FRONT   = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BACK    = 48,
    parameter int         V_VISIBLE = 480,
    parameter int         V_FRONT   = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BACK    = 33,
    parameter logic [7:0] FG_COLOR  = 8'hFF,
    parameter logic [7:0] BG_COLOR  = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_line_scanout_if.master vram,
    output logic               hsync,
    output logic               vsync,
    output logic [7:0]         rgb,
    output logic               underrun
);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST_VIS = 10'(V_VISIBLE - 1);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [H_VISIBLE-1:0] PIX_ONE = {{(H_VISIBLE-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    logic [7:0]           div_r;
    logic [9:0]           hcount_r;
    logic [9:0]           vcount_r;
    logic [1:0]           state_r;
    logic [1:0]           state_s;
    logic [H_VISIBLE-1:0] fetch_buf_r;
    logic [H_VISIBLE-1:0] disp_buf_r;
    logic                 hsync_r;
    logic                 vsync_r;
    logic [7:0]           rgb_r;
    logic                 underrun_r;
    logic                 vram_rd_r;
    logic [8:0]           vram_addr_r;
    logic                 vram_turn_r;

    logic                 tick_s;
    logic                 h_wrap_s;
    logic                 has_next_s;
    logic [8:0]           next_line_s;
    logic                 fetch_start_s;
    logic                 accept_s;
    logic                 pix_s;
    logic                 visible_s;

    // Timing decode: pixel tick, line wrap, next-line selection and pixel lookup.
    always_comb begin
        tick_s        = (div_r == DIV_LAST);
        h_wrap_s      = tick_s && (hcount_r == H_LAST);
        has_next_s    = 1'b0;
        next_line_s   = 9'd0;
        if (vcount_r < V_LAST_VIS) begin
            has_next_s  = 1'b1;
            next_line_s = vcount_r[8:0] + 9'd1;
        end else if (vcount_r == V_LAST) begin
            has_next_s  = 1'b1;
            next_line_s = 9'd0;
        end else begin
            has_next_s  = 1'b0;
            next_line_s = 9'd0;
        end
        fetch_start_s = tick_s && (hcount_r == H_VIS) && has_next_s;
        accept_s      = (state_r == ST_WAIT) && vram.vram_valid;
        pix_s         = |(disp_buf_r & (PIX_ONE << hcount_r));
        visible_s     = (hcount_r < H_VIS) && (vcount_r < V_VIS);
    end

    // Fetch FSM next state; the line wrap always returns to IDLE.
    always_comb begin
        state_s = state_r;
        if (h_wrap_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = fetch_start_s ? ST_REQ : ST_IDLE;
                ST_REQ:   state_s = ST_WAIT;
                ST_WAIT:  state_s = accept_s ? ST_READY : ST_WAIT;
                ST_READY: state_s = ST_READY;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // Pixel-tick divider and horizontal/vertical position counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r    <= 8'd0;
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else begin
            div_r <= tick_s ? 8'd0 : div_r + 8'd1;
            if (tick_s) begin
                if (hcount_r == H_LAST) begin
                    hcount_r <= 10'd0;
                    vcount_r <= (vcount_r == V_LAST) ? 10'd0 : vcount_r + 10'd1;
                end else begin
                    hcount_r <= hcount_r + 10'd1;
                end
            end
        end
    end

    // Fetch FSM state, line buffers and the sticky underrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            fetch_buf_r <= '0;
            disp_buf_r  <= '0;
            underrun_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                fetch_buf_r <= vram.vram_line;
            end
            // Data arriving on the wrap tick itself still makes the deadline.
            if (h_wrap_s) begin
                if (accept_s) begin
                    disp_buf_r <= vram.vram_line;
                end else if (state_r == ST_READY) begin
                    disp_buf_r <= fetch_buf_r;
                end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
                    disp_buf_r <= '0;
                    underrun_r <= 1'b1;
                end
            end
        end
    end

    // Registered video and VRAM-port outputs, one clk behind the counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            rgb_r       <= 8'h00;
            vram_rd_r   <= 1'b0;
            vram_addr_r <= 9'd0;
            vram_turn_r <= 1'b1;
        end else begin
            hsync_r     <= !((hcount_r >= HS_START) && (hcount_r < HS_END));
            vsync_r     <= !((vcount_r >= VS_START) && (vcount_r < VS_END));
            rgb_r       <= visible_s ? (pix_s ? FG_COLOR : BG_COLOR) : 8'h00;
            vram_rd_r   <= (state_s == ST_REQ);
            vram_addr_r <= (state_s == ST_REQ) ? next_line_s : vram_addr_r;
            vram_turn_r <= !((state_s == ST_REQ) || (state_s == ST_WAIT));
        end
    end

    assign hsync          = hsync_r;
    assign vsync          = vsync_r;
    assign rgb            = rgb_r;
    assign underrun       = underrun_r;
    assign vram.vram_rd   = vram_rd_r;
    assign vram.vram_addr = vram_addr_r;
    assign vram.vram_turn = vram_turn_r;
endmodule

// File: tb/tb_vga_line_scanout.sv
// Bench for vga_line_scanout on a shrunken raster (24x12 visible, 40x20 total,
// CLK_DIV=4) with a cycle-level reference model and a per-line pixel scoreboard.
module tb_vga_line_scanout;
    localparam int W       = 24;
    localparam int DIV     = 4;
    localparam int HTOT    = 40;
    localparam int VTOT    = 20;
    localparam int LINE_CK = HTOT * DIV;
    localparam int FRAME   = LINE_CK * VTOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync, underrun;
    logic [7:0] rgb;

    vga_line_scanout_if #(.LINE_W(W)) vif ();

    vga_line_scanout #(
        .CLK_DIV(DIV), .H_VISIBLE(W), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3),
        .FG_COLOR(8'hFF), .BG_COLOR(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vram(vif),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          line;
        logic [W-1:0] data;
    } line_t;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    lat_cfg [12];
    int    stray_cyc [3];
    line_t sb [$];

    // Monitor/responder state
    line_t        e;
    logic         busy, und_pend, und_exp, rd_exp, turn_exp, ok, cap_bad, prev_vs;
    int           n_rd, lat, turn_end, und_from, hs_run, vs_last, g, h, v, ln, inl;
    logic [8:0]   addr_exp;
    logic [W-1:0] data, cap;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model, VRAM responder and scoreboard, evaluated mid-cycle.
    initial begin
        vif.vram_valid = 1'b0;
        vif.vram_line  = '0;
        forever begin
            @(negedge clk);
            if (cyc == 0) begin
                busy = 1'b0; und_pend = 1'b0; und_exp = 1'b0; cap_bad = 1'b0;
                hs_run = 0; vs_last = -1; prev_vs = 1'b1; cap = '0;
                sb.delete();
                e.line = 0; e.data = '0;
                sb.push_back(e);
                vif.vram_valid = 1'b0;
                chk("rst_hsync", hsync, 1'b1);
                chk("rst_vsync", vsync, 1'b1);
                chk("rst_rgb", rgb, 8'h00);
                chk("rst_vram_rd", vif.vram_rd, 1'b0);
                chk("rst_vram_addr", vif.vram_addr, 9'd0);
                chk("rst_vram_turn", vif.vram_turn, 1'b1);
                chk("rst_underrun", underrun, 1'b0);
            end else begin
                g = (cyc - 1) / DIV;
                h = g % HTOT;
                v = (g / HTOT) % VTOT;
                chk("hsync", hsync, !(h >= 28 && h < 34));
                chk("vsync", vsync, !(v >= 15 && v < 17));
                if (!hsync) hs_run++;
                else if (hs_run > 0) begin
                    chk("hsync_width", hs_run, 6 * DIV);
                    hs_run = 0;
                end
                if (!vsync && prev_vs) begin
                    if (vs_last >= 0) chk("frame_period", cyc - vs_last, FRAME);
                    vs_last = cyc;
                end
                prev_vs = vsync;
                if (h < W && v < 12) begin
                    if ((cyc - 1) % DIV == 0) cap[h] = (rgb == 8'hFF);
                    else if ((rgb == 8'hFF) != cap[h]) cap_bad = 1'b1;
                    if (rgb != 8'hFF && rgb != 8'h00) cap_bad = 1'b1;
                    if (h == W - 1 && (cyc - 1) % DIV == DIV - 1) begin
                        if (sb.size() == 0) chk("sb_underflow", 1, 0);
                        else begin
                            e = sb.pop_front();
                            chk("line_no", v, e.line);
                            chk("line_pixels", {cap_bad, cap}, {1'b0, e.data});
                        end
                        cap_bad = 1'b0;
                    end
                end else begin
                    chk("blank_rgb", rgb, 8'h00);
                end
                ln  = (cyc / LINE_CK) % VTOT;
                inl = cyc % LINE_CK;
                rd_exp   = (inl == 100) && (ln < 11 || ln == 19);
                addr_exp = (ln == 19) ? 9'd0 : 9'(ln + 1);
                chk("vram_rd", vif.vram_rd, rd_exp);
                if (rd_exp) begin
                    chk("vram_addr", vif.vram_addr, addr_exp);
                    busy = 1'b1;
                    n_rd = cyc;
                    lat  = lat_cfg[addr_exp];
                    data = (addr_exp == 9'd0) ? W'(1) : W'($urandom);
                    ok   = (lat >= 1 && lat <= 59);
                    turn_end = ok ? n_rd + lat + 1 : n_rd + 60;
                    if (!ok) begin
                        und_pend = 1'b1;
                        und_from = n_rd + 60;
                    end
                    e.line = int'(addr_exp);
                    e.data = ok ? data : '0;
                    sb.push_back(e);
                end
                turn_exp = !(busy && cyc >= n_rd && cyc < turn_end);
                chk("vram_turn", vif.vram_turn, turn_exp);
                if (und_pend && cyc >= und_from) und_exp = 1'b1;
                chk("underrun", underrun, und_exp);
                vif.vram_valid = 1'b0;
                if (busy && lat > 0 && cyc == n_rd + lat) begin
                    vif.vram_valid = 1'b1;
                    vif.vram_line  = data;
                end
                for (int i = 0; i < 3; i++) begin
                    if (cyc == stray_cyc[i]) begin
                        vif.vram_valid = 1'b1;
                        vif.vram_line  = W'($urandom) | W'(1);
                    end
                end
                if (busy && cyc >= n_rd + 100) busy = 1'b0;
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Directed sequence: normal frame with boundary/stray valids, a missed
    // deadline in frame 2, then a reset while a fetch is outstanding.
    initial begin
        for (int i = 0; i < 12; i++) lat_cfg[i] = 3;
        lat_cfg[0]   = 5;
        lat_cfg[5]   = 59;
        stray_cyc[0] = 2 * LINE_CK + 20;
        stray_cyc[1] = 2 * LINE_CK + 130;
        stray_cyc[2] = -1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(FRAME + 100);
        lat_cfg[10] = 0;
        lat_cfg[5]  = 7;
        wait_cyc(FRAME + 12 * LINE_CK);
        lat_cfg[10] = 3;
        lat_cfg[3]  = 40;
        wait_cyc(2 * FRAME + 2 * LINE_CK + 110);
        stray_cyc[0] = -1;
        stray_cyc[1] = -1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray_cyc[2] = 20;
        wait_cyc(2 * LINE_CK + 10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, %0d failed so far", fails);
        $fatal(1, "watchdog expired");
    end
endmodule
